// File: rtl/v_wb_queue.sv
// Vector writeback collector: up to 3 results/cycle into an in-order ring, up to 2 drained/cycle to the regfile.
// Latency 1 cycle accept->wb; readies depend only on registered occupancy, so there is no valid->ready path.
module v_wb_queue #(
  parameter int VREG_DW = 256,
  parameter int VREG_AW = 5,
  parameter int DEPTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       p0_valid_i,
  output logic                       p0_ready_o,
  input  logic [VREG_AW-1:0]         p0_addr_i,
  input  logic [VREG_DW-1:0]         p0_data_i,
  input  logic                       p1_valid_i,
  output logic                       p1_ready_o,
  input  logic [VREG_AW-1:0]         p1_addr_i,
  input  logic [VREG_DW-1:0]         p1_data_i,
  input  logic                       p2_valid_i,
  output logic                       p2_ready_o,
  input  logic [VREG_AW-1:0]         p2_addr_i,
  input  logic [VREG_DW-1:0]         p2_data_i,
  output logic                       wb1_en_o,
  output logic [VREG_AW-1:0]         wb1_addr_o,
  output logic [VREG_DW-1:0]         wb1_data_o,
  output logic                       wb2_en_o,
  output logic [VREG_AW-1:0]         wb2_addr_o,
  output logic [VREG_DW-1:0]         wb2_data_o,
  input  logic [VREG_AW-1:0]         q_addr_i,
  output logic                       q_busy_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [VREG_AW-1:0] addr_q [DEPTH];
  logic [VREG_DW-1:0] data_q [DEPTH];
  logic [PW-1:0]      head, tail, head_p1, idx1, idx2;
  logic [CW-1:0]      cnt, free;
  logic               acc0, acc1, acc2, busy;
  logic [1:0]         n_acc, n_drn;

  assign free       = CW'(DEPTH) - cnt;
  assign p0_ready_o = !rst && (free >= CW'(1));
  assign p1_ready_o = !rst && (free >= CW'(2));
  assign p2_ready_o = !rst && (free >= CW'(3));

  assign acc0  = p0_valid_i && p0_ready_o;
  assign acc1  = p1_valid_i && p1_ready_o;
  assign acc2  = p2_valid_i && p2_ready_o;
  assign n_acc = {1'b0, acc0} + {1'b0, acc1} + {1'b0, acc2};

  // Compact accepted results so there are never holes between tail entries.
  assign idx1 = tail + PW'(acc0);
  assign idx2 = tail + PW'(acc0) + PW'(acc1);

  always_ff @(posedge clk) begin
    if (acc0) begin
      addr_q[tail] <= p0_addr_i;
      data_q[tail] <= p0_data_i;
    end
    if (acc1) begin
      addr_q[idx1] <= p1_addr_i;
      data_q[idx1] <= p1_data_i;
    end
    if (acc2) begin
      addr_q[idx2] <= p2_addr_i;
      data_q[idx2] <= p2_data_i;
    end
  end

  // The younger entry always goes to wb2 because the regfile applies is2 last.
  assign head_p1    = head + PW'(1);
  assign wb1_en_o   = !rst && (cnt >= CW'(1));
  assign wb2_en_o   = !rst && (cnt >= CW'(2));
  assign wb1_addr_o = wb1_en_o ? addr_q[head]    : '0;
  assign wb1_data_o = wb1_en_o ? data_q[head]    : '0;
  assign wb2_addr_o = wb2_en_o ? addr_q[head_p1] : '0;
  assign wb2_data_o = wb2_en_o ? data_q[head_p1] : '0;
  assign n_drn      = {1'b0, wb1_en_o} + {1'b0, wb2_en_o};

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head + PW'(n_drn);
      tail <= tail + PW'(n_acc);
      cnt  <= cnt + CW'(n_acc) - CW'(n_drn);
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < cnt) && (addr_q[head + PW'(k)] == q_addr_i)) busy = 1'b1;
    end
  end

  assign q_busy_o = busy && !rst && (q_addr_i != '0);
  assign count_o  = rst ? '0 : cnt;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) cnt <= CW'(DEPTH));
endmodule

// File: tb/tb_v_wb_queue.sv
// Bench for v_wb_queue: directed scenarios plus randomized traffic against a queue-based model.
module tb_v_wb_queue;
  localparam int DW = 256, AW = 5, DEPTH = 8, CW = 4;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          p0_valid_i, p1_valid_i, p2_valid_i;
  logic          p0_ready_o, p1_ready_o, p2_ready_o;
  logic [AW-1:0] p0_addr_i, p1_addr_i, p2_addr_i, q_addr_i;
  logic [DW-1:0] p0_data_i, p1_data_i, p2_data_i;
  logic          wb1_en_o, wb2_en_o, q_busy_o;
  logic [AW-1:0] wb1_addr_o, wb2_addr_o;
  logic [DW-1:0] wb1_data_o, wb2_data_o;
  logic [CW-1:0] count_o;

  ent_t          mq[$];
  logic [DW-1:0] rf_m [32];
  logic [DW-1:0] rf_d [32];
  int            vecs = 0, errs = 0;

  always #5 clk = ~clk;

  v_wb_queue #(.VREG_DW(DW), .VREG_AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .p0_valid_i(p0_valid_i), .p0_ready_o(p0_ready_o), .p0_addr_i(p0_addr_i), .p0_data_i(p0_data_i),
    .p1_valid_i(p1_valid_i), .p1_ready_o(p1_ready_o), .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
    .p2_valid_i(p2_valid_i), .p2_ready_o(p2_ready_o), .p2_addr_i(p2_addr_i), .p2_data_i(p2_data_i),
    .wb1_en_o(wb1_en_o), .wb1_addr_o(wb1_addr_o), .wb1_data_o(wb1_data_o),
    .wb2_en_o(wb2_en_o), .wb2_addr_o(wb2_addr_o), .wb2_data_o(wb2_data_o),
    .q_addr_i(q_addr_i), .q_busy_o(q_busy_o), .count_o(count_o)
  );

  // Regfile fed from the DUT's write ports; is2 applied after is1, addr 0 ignored.
  always @(negedge clk) begin
    if (wb1_en_o && wb1_addr_o != '0) rf_d[wb1_addr_o] = wb1_data_o;
    if (wb2_en_o && wb2_addr_o != '0) rf_d[wb2_addr_o] = wb2_data_o;
  end

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Model: drain the two oldest into the regfile model, then append accepted results in p0,p1,p2 order.
  task automatic advance();
    bit   a0, a1, a2;
    int   fr;
    ent_t e0, e1, e2, e;
    fr = DEPTH - mq.size();
    a0 = p0_valid_i && !rst && fr >= 1;
    a1 = p1_valid_i && !rst && fr >= 2;
    a2 = p2_valid_i && !rst && fr >= 3;
    e0 = {p0_addr_i, p0_data_i};
    e1 = {p1_addr_i, p1_data_i};
    e2 = {p2_addr_i, p2_data_i};
    @(posedge clk);
    if (rst) mq.delete();
    else begin
      for (int k = 0; k < 2; k++) begin
        if (mq.size() > 0) begin
          e = mq.pop_front();
          if (e.a != '0) rf_m[e.a] = e.d;
        end
      end
      if (a0) mq.push_back(e0);
      if (a1) mq.push_back(e1);
      if (a2) mq.push_back(e2);
    end
    #1;
    if (a0) p0_valid_i = 1'b0;
    if (a1) p1_valid_i = 1'b0;
    if (a2) p2_valid_i = 1'b0;
  endtask

  task automatic refill(input int n);
    if (n > 0 && !p0_valid_i) begin p0_valid_i = 1; p0_addr_i = AW'($urandom_range(1, 31)); p0_data_i = rnd_data(); end
    if (n > 1 && !p1_valid_i) begin p1_valid_i = 1; p1_addr_i = AW'($urandom_range(1, 31)); p1_data_i = rnd_data(); end
    if (n > 2 && !p2_valid_i) begin p2_valid_i = 1; p2_addr_i = AW'($urandom_range(1, 31)); p2_data_i = rnd_data(); end
  endtask

  task automatic flush();
    p0_valid_i = 0; p1_valid_i = 0; p2_valid_i = 0;
    for (int i = 0; i < 10 && mq.size() > 0; i++) advance();
    advance();
  endtask

  task automatic test_reset();
    rst = 1; q_addr_i = 5'd7;
    advance(); advance();
    vecs++;
    if ({count_o, wb1_en_o, wb2_en_o, q_busy_o} !== 7'b0) begin
      errs++; $display("FAIL reset_state count=%0d wb1=%0b wb2=%0b busy=%0b want all 0", count_o, wb1_en_o, wb2_en_o, q_busy_o);
    end
    vecs++;
    if ({wb1_addr_o, wb2_addr_o, wb1_data_o, wb2_data_o} !== '0) begin
      errs++; $display("FAIL reset_wb_zero a1=%0d a2=%0d want 0", wb1_addr_o, wb2_addr_o);
    end
    vecs++;
    if ({p0_ready_o, p1_ready_o, p2_ready_o} !== 3'b000) begin
      errs++; $display("FAIL reset_ready got %b want 000", {p0_ready_o, p1_ready_o, p2_ready_o});
    end
    rst = 0; #1;
    vecs++;
    if ({p0_ready_o, p1_ready_o, p2_ready_o} !== 3'b111) begin
      errs++; $display("FAIL post_reset_ready got %b want 111", {p0_ready_o, p1_ready_o, p2_ready_o});
    end
  endtask

  task automatic test_single();
    logic [DW-1:0] pat;
    pat = {32{8'hA5}};
    p0_valid_i = 1; p0_addr_i = 5'd3; p0_data_i = pat; #1;
    vecs++;
    if (wb1_en_o !== 1'b0) begin errs++; $display("FAIL single_no_bypass wb1_en=%0b want 0", wb1_en_o); end
    advance();
    vecs++;
    if ({wb1_en_o, wb1_addr_o, wb2_en_o} !== {1'b1, 5'd3, 1'b0} || wb1_data_o !== pat || count_o !== 4'd1) begin
      errs++; $display("FAIL single_wb en1=%0b a1=%0d en2=%0b cnt=%0d want 1,3,0,1", wb1_en_o, wb1_addr_o, wb2_en_o, count_o);
    end
    advance();
    vecs++;
    if (count_o !== 4'd0 || wb1_en_o !== 1'b0) begin errs++; $display("FAIL single_drained cnt=%0d en1=%0b want 0,0", count_o, wb1_en_o); end
  endtask

  task automatic test_triple();
    logic [DW-1:0] d0, d1, d2;
    d0 = rnd_data(); d1 = rnd_data(); d2 = rnd_data();
    p0_valid_i = 1; p0_addr_i = 5'd1; p0_data_i = d0;
    p1_valid_i = 1; p1_addr_i = 5'd2; p1_data_i = d1;
    p2_valid_i = 1; p2_addr_i = 5'd4; p2_data_i = d2;
    advance();
    vecs++;
    if ({wb1_en_o, wb1_addr_o, wb2_en_o, wb2_addr_o, count_o} !== {1'b1, 5'd1, 1'b1, 5'd2, 4'd3} || wb1_data_o !== d0 || wb2_data_o !== d1) begin
      errs++; $display("FAIL triple_first a1=%0d a2=%0d cnt=%0d want 1,2,3", wb1_addr_o, wb2_addr_o, count_o);
    end
    advance();
    vecs++;
    if ({wb1_en_o, wb1_addr_o, wb2_en_o, count_o} !== {1'b1, 5'd4, 1'b0, 4'd1} || wb1_data_o !== d2) begin
      errs++; $display("FAIL triple_second en1=%0b a1=%0d en2=%0b cnt=%0d want 1,4,0,1", wb1_en_o, wb1_addr_o, wb2_en_o, count_o);
    end
    flush();
  endtask

  task automatic test_backpressure();
    refill(3);
    for (int i = 0; i < 10 && mq.size() < 6; i++) begin advance(); refill(3); end
    vecs++;
    if (count_o !== 4'd6 || {p0_ready_o, p1_ready_o, p2_ready_o} !== 3'b110) begin
      errs++; $display("FAIL bp_at6 cnt=%0d rdy=%b want 6,110", count_o, {p0_ready_o, p1_ready_o, p2_ready_o});
    end
    for (int i = 0; i < 3; i++) begin
      advance(); refill(2);
      vecs++;
      if (count_o !== 4'd6 || p2_ready_o !== 1'b0) begin
        errs++; $display("FAIL bp_hold cyc %0d cnt=%0d rdy2=%0b want 6,0", i, count_o, p2_ready_o);
      end
    end
    p0_valid_i = 0; p1_valid_i = 0;
    advance();
    vecs++;
    if (count_o !== 4'd4 || p2_ready_o !== 1'b1) begin
      errs++; $display("FAIL bp_release cnt=%0d rdy2=%0b want 4,1", count_o, p2_ready_o);
    end
    advance();
    vecs++;
    if (count_o !== 4'd3) begin errs++; $display("FAIL bp_p2_accepted cnt=%0d want 3", count_o); end
    flush();
  endtask

  task automatic test_same_addr();
    logic [DW-1:0] x, y;
    x = rnd_data(); y = rnd_data();
    p0_valid_i = 1; p0_addr_i = 5'd5; p0_data_i = x;
    p1_valid_i = 1; p1_addr_i = 5'd5; p1_data_i = y;
    advance();
    vecs++;
    if ({wb1_en_o, wb1_addr_o, wb2_en_o, wb2_addr_o} !== {1'b1, 5'd5, 1'b1, 5'd5} || wb1_data_o !== x || wb2_data_o !== y) begin
      errs++; $display("FAIL same_addr_pair a1=%0d a2=%0d en=%0b%0b want 5,5,11", wb1_addr_o, wb2_addr_o, wb1_en_o, wb2_en_o);
    end
    advance();
    vecs++;
    if (rf_d[5] !== y) begin errs++; $display("FAIL same_addr_final rf[5]=%h want %h", rf_d[5], y); end
  endtask

  task automatic test_busy();
    p0_valid_i = 1; p0_addr_i = 5'd7; p0_data_i = rnd_data();
    p1_valid_i = 1; p1_addr_i = 5'd9; p1_data_i = rnd_data();
    p2_valid_i = 1; p2_addr_i = 5'd0; p2_data_i = rnd_data();
    q_addr_i = 5'd9; #1;
    vecs++;
    if (q_busy_o !== 1'b0) begin errs++; $display("FAIL busy_not_incoming got %0b want 0", q_busy_o); end
    advance();
    vecs++;
    if (q_busy_o !== 1'b1) begin errs++; $display("FAIL busy_9 got %0b want 1", q_busy_o); end
    q_addr_i = 5'd8; #1;
    vecs++;
    if (q_busy_o !== 1'b0) begin errs++; $display("FAIL busy_8 got %0b want 0", q_busy_o); end
    q_addr_i = 5'd0; #1;
    vecs++;
    if (q_busy_o !== 1'b0) begin errs++; $display("FAIL busy_0 got %0b want 0", q_busy_o); end
    q_addr_i = 5'd9;
    advance();
    vecs++;
    if (q_busy_o !== 1'b0) begin errs++; $display("FAIL busy_after_drain got %0b want 0", q_busy_o); end
    flush();
  endtask

  task automatic test_reset_mid();
    refill(3);
    for (int i = 0; i < 10 && mq.size() < 5; i++) begin advance(); refill(3); end
    vecs++;
    if (count_o !== 4'd5) begin errs++; $display("FAIL mid_build cnt=%0d want 5", count_o); end
    p0_valid_i = 0; p1_valid_i = 0; p2_valid_i = 0;
    rst = 1; #1;
    vecs++;
    if ({wb1_en_o, wb2_en_o, count_o} !== 6'b0) begin
      errs++; $display("FAIL mid_rst_cycle en=%0b%0b cnt=%0d want 00,0", wb1_en_o, wb2_en_o, count_o);
    end
    advance();
    rst = 0; #1;
    vecs++;
    if ({wb1_en_o, wb2_en_o, count_o} !== 6'b0) begin
      errs++; $display("FAIL mid_after_rst en=%0b%0b cnt=%0d want 00,0", wb1_en_o, wb2_en_o, count_o);
    end
  endtask

  task automatic test_random();
    int   c;
    ent_t x1, x2;
    bit   eb;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!p0_valid_i && $urandom_range(0, 1)) begin p0_valid_i = 1; p0_addr_i = AW'($urandom); p0_data_i = rnd_data(); end
      if (!p1_valid_i && $urandom_range(0, 1)) begin p1_valid_i = 1; p1_addr_i = AW'($urandom); p1_data_i = rnd_data(); end
      if (!p2_valid_i && $urandom_range(0, 2) == 0) begin p2_valid_i = 1; p2_addr_i = AW'($urandom); p2_data_i = rnd_data(); end
      if (mq.size() > 0 && $urandom_range(0, 1)) q_addr_i = mq[$urandom_range(0, mq.size() - 1)].a;
      else q_addr_i = AW'($urandom);
      #1;
      c  = mq.size();
      x1 = (c >= 1) ? mq[0] : '0;
      x2 = (c >= 2) ? mq[1] : '0;
      eb = 1'b0;
      foreach (mq[i]) if (mq[i].a == q_addr_i && q_addr_i != '0) eb = 1'b1;
      vecs++;
      if (count_o !== CW'(c) || {p0_ready_o, p1_ready_o, p2_ready_o} !== {c <= 7, c <= 6, c <= 5}) begin
        errs++; $display("FAIL rnd_count_ready cyc %0d cnt=%0d rdy=%b want cnt %0d", cyc, count_o, {p0_ready_o, p1_ready_o, p2_ready_o}, c);
      end
      vecs++;
      if ({wb1_en_o, wb1_addr_o, wb1_data_o} !== {c >= 1, x1} || {wb2_en_o, wb2_addr_o, wb2_data_o} !== {c >= 2, x2}) begin
        errs++; $display("FAIL rnd_wb cyc %0d en=%0b%0b a1=%0d a2=%0d want en=%0b%0b a1=%0d a2=%0d", cyc,
                         wb1_en_o, wb2_en_o, wb1_addr_o, wb2_addr_o, c >= 1, c >= 2, x1.a, x2.a);
      end
      vecs++;
      if (q_busy_o !== eb) begin errs++; $display("FAIL rnd_busy cyc %0d q=%0d got %0b want %0b", cyc, q_addr_i, q_busy_o, eb); end
      advance();
    end
    flush();
    for (int r = 1; r < 32; r++) begin
      vecs++;
      if (rf_d[r] !== rf_m[r]) begin errs++; $display("FAIL rnd_regfile r%0d got %h want %h", r, rf_d[r], rf_m[r]); end
    end
  endtask

  initial begin
    rst = 1;
    p0_valid_i = 0; p1_valid_i = 0; p2_valid_i = 0;
    p0_addr_i = '0; p1_addr_i = '0; p2_addr_i = '0; q_addr_i = '0;
    p0_data_i = '0; p1_data_i = '0; p2_data_i = '0;
    for (int r = 0; r < 32; r++) begin rf_m[r] = '0; rf_d[r] = '0; end
    #2;
    test_reset();
    test_single();
    test_triple();
    test_backpressure();
    test_same_addr();
    test_busy();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
